// File: rtl/lsu_ctrl.sv
// Load/store sequencer: turns a decoded load/store into one req/gnt/rvalid
// transaction on the data-memory port, stalls the core until it completes,
// and returns byte-lane-extracted, sign/zero-extended load data.
//
// Handshake: mem_req is held high with all mem_* outputs stable until a cycle
// in which mem_gnt=1; the request is then accepted and mem_req drops in the
// next cycle. Exactly one mem_rvalid is expected per accepted request and is
// only honoured in WAIT; mem_gnt is only honoured in REQ.
module lsu_ctrl #(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ls_valid,
    input  logic          ls_we,
    input  logic [2:0]    ls_func3,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_stall,
    output logic          ls_done,
    output logic          ls_err,
    output logic [DW-1:0] ls_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [3:0]    mem_be,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_gnt,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic [1:0]    dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t state;

    // Captured attributes of the access in flight, used for load extraction.
    logic       we_q;
    logic [2:0] func3_q;
    logic [1:0] off_q;

    // Decode of the incoming request.
    logic          func3_ok;
    logic          align_ok;
    logic          legal;
    logic [3:0]    be_next;
    logic [DW-1:0] wdata_next;

    // Lane extraction of the returned read data.
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [DW-1:0] load_data;

    assign dbg_state = state;
    assign ls_stall  = ls_valid & ~ls_done;

    // Legality, byte enables and lane-replicated store data for the request.
    always_comb begin
        func3_ok   = 1'b0;
        align_ok   = 1'b0;
        be_next    = 4'b1111;
        wdata_next = ls_wdata;
        if (ls_we) begin
            func3_ok = (ls_func3 == 3'd0) || (ls_func3 == 3'd1) || (ls_func3 == 3'd2);
        end else begin
            func3_ok = (ls_func3 == 3'd0) || (ls_func3 == 3'd1) || (ls_func3 == 3'd2) ||
                       (ls_func3 == 3'd4) || (ls_func3 == 3'd5);
        end
        case (ls_func3[1:0])
            2'd0: begin
                align_ok   = 1'b1;
                be_next    = 4'b0001 << ls_addr[1:0];
                wdata_next = {4{ls_wdata[7:0]}};
            end
            2'd1: begin
                align_ok   = ~ls_addr[0];
                be_next    = ls_addr[1] ? 4'b1100 : 4'b0011;
                wdata_next = {2{ls_wdata[15:0]}};
            end
            2'd2: begin
                align_ok   = (ls_addr[1:0] == 2'b00);
                be_next    = 4'b1111;
                wdata_next = ls_wdata;
            end
            default: begin
                align_ok   = 1'b0;
                be_next    = 4'b1111;
                wdata_next = ls_wdata;
            end
        endcase
        legal = func3_ok & align_ok;
    end

    // Select the addressed lane and extend it according to the captured funct3.
    always_comb begin
        byte_sel  = mem_rdata[{off_q, 3'b000} +: 8];
        half_sel  = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_data = mem_rdata;
        case (func3_q)
            3'd0:    load_data = {{24{byte_sel[7]}}, byte_sel};
            3'd4:    load_data = {24'd0, byte_sel};
            3'd1:    load_data = {{16{half_sel[15]}}, half_sel};
            3'd5:    load_data = {16'd0, half_sel};
            default: load_data = mem_rdata;
        endcase
        if (we_q) begin
            load_data = '0;
        end
    end

    // Sequencer FSM with registered memory-port and completion outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            we_q      <= 1'b0;
            func3_q   <= 3'd0;
            off_q     <= 2'd0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'd0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ls_done   <= 1'b0;
            ls_err    <= 1'b0;
            ls_rdata  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    ls_done  <= 1'b0;
                    ls_err   <= 1'b0;
                    ls_rdata <= '0;
                    if (ls_valid) begin
                        if (legal) begin
                            we_q      <= ls_we;
                            func3_q   <= ls_func3;
                            off_q     <= ls_addr[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= ls_we;
                            mem_be    <= be_next;
                            mem_addr  <= {ls_addr[AW-1:2], 2'b00};
                            mem_wdata <= ls_we ? wdata_next : '0;
                            state     <= S_REQ;
                        end else begin
                            // Illegal access: report straight away, no memory traffic.
                            ls_done <= 1'b1;
                            ls_err  <= 1'b1;
                            state   <= S_RESP;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req <= 1'b0;
                        state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        ls_rdata <= load_data;
                        ls_done  <= 1'b1;
                        ls_err   <= 1'b0;
                        state    <= S_RESP;
                    end
                end
                S_RESP: begin
                    ls_done  <= 1'b0;
                    ls_err   <= 1'b0;
                    ls_rdata <= '0;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store sequencer for the single-cycle core. It turns the decoder's memory-access request into a req/gnt/rvalid transaction on the data-memory port and stalls the core until the access completes. It generates byte enables and write-lane replication, and returns sign- or zero-extended load data to the rd write-back mux (RD_MEM path). It replaces the tied-off `mem_en` with a real multi-cycle access.

## Interface
Parameters:
- AW, 32, address width
- DW, 32, data width; only 32 is supported (4 byte lanes)

Ports:
- clk  in  1  core clock; one clock domain
- rst_n  in  1  reset, asynchronous, active-low
- ls_valid  in  1  current instruction is a load or store (is_mem_load | is_mem_store); held with all ls_* inputs until ls_done
- ls_we  in  1  1 = store, 0 = load
- ls_func3  in  3  funct3 of the load/store
- ls_addr  in  AW  effective address (rs1 + imm)
- ls_wdata  in  DW  rs2 store data
- ls_stall  out  1  freeze PC and register-file write
- ls_done  out  1  one-cycle completion pulse
- ls_err  out  1  with ls_done: misaligned address or illegal func3
- ls_rdata  out  DW  extended load data, valid with ls_done
- mem_req  out  1  memory request
- mem_we  out  1  memory write
- mem_be  out  4  byte enables
- mem_addr  out  AW  word-aligned address {ls_addr[AW-1:2],2'b00}
- mem_wdata  out  DW  lane-replicated store data
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response (read data or write ack) this cycle
- mem_rdata  in  DW  read data, valid with mem_rvalid

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - ls_valid=1 and legal: capture we, func3, addr[1:0], be, aligned address and replicated wdata into registers; go to REQ.
  - ls_valid=1 and illegal: go to RESP with err set; no memory access occurs.
  - Otherwise: stay in IDLE.
- **REQ**: mem_req=1, driven from the captured registers. On mem_gnt, go to WAIT; otherwise stay with all mem_* outputs held stable.
- **WAIT**: on mem_rvalid, register the extended load data (stores: 0) and go to RESP.
- **RESP**: ls_done=1 for exactly one cycle, then unconditionally go to IDLE.
- Legality:
  - Loads: func3 must be 0, 1, 2, 4 or 5.
  - Stores: func3 must be 0, 1 or 2.
  - Halfword accesses require addr[0]=0; word accesses require addr[1:0]=0.
  - Any failure sets ls_err=1 and ls_rdata=0 in RESP.
- Byte enables:
  - Byte access: be = 4'b0001 << addr[1:0].
  - Halfword access: be = addr[1] ? 4'b1100 : 4'b0011.
  - Word access: be = 4'b1111.
  - Loads use the same be values with mem_we=0.
- Write data:
  - SB: {4{wdata[7:0]}}
  - SH: {2{wdata[15:0]}}
  - SW: wdata
- Load extraction, selecting the lane with captured addr[1:0]:
  - LB: byte, sign-extended.
  - LBU: byte, zero-extended.
  - LH: halfword from lane addr[1], sign-extended.
  - LHU: halfword from lane addr[1], zero-extended.
  - LW: full word.
- ls_stall = ls_valid & ~ls_done (combinational).
- mem_rvalid is ignored in IDLE, REQ and RESP. mem_gnt is ignored outside REQ.

## Timing
- Reset (async assert) values:
  - State is IDLE.
  - mem_req, mem_we, mem_be, mem_addr, mem_wdata, ls_done, ls_err and ls_rdata are all 0.
  - ls_stall follows ls_valid.
- Reset mid-transaction: the access is abandoned and the FSM returns to IDLE. A stale mem_rvalid arriving after reset release is ignored.
- Minimum latency with zero-wait memory:
  - T0: ls_valid seen in IDLE.
  - T1: mem_req asserted, mem_gnt returned.
  - T2: mem_rvalid returned.
  - T3: ls_done asserted.
  - Stall is high T0–T2 and low at T3.
- Each cycle without mem_gnt in REQ, or without mem_rvalid in WAIT, adds one cycle.
- Illegal access: ls_done and ls_err are asserted at T1; mem_req is never raised.
- Back-to-back accesses: RESP always returns to IDLE, so the next access is sampled in the cycle after ls_done. Minimum spacing is 4 cycles per access.
- mem_req deasserts in the cycle after mem_gnt. Only one transaction is outstanding at a time.

## Test plan
- **LW, zero-wait memory:** addr=0x100, mem_rdata=0xDEADBEEF with gnt at T1 and rvalid at T2 -> ls_done at T3; ls_rdata=0xDEADBEEF; mem_be=4'b1111; mem_addr=0x100; stall high for exactly 3 cycles.
- **LB / LBU at addr=0x103:** mem_rdata=0x80xxxxxx -> LB returns 0xFFFFFF80 and LBU returns 0x00000080; mem_be=4'b1000.
- **SH at addr=0x202:** ls_wdata=0x1234ABCD -> mem_we=1, mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_addr=0x200. mem_gnt withheld for 3 cycles -> mem_* held stable throughout; ls_done 2 cycles after the gnt cycle.
- **Misaligned LW at addr=0x101, plus load func3=3:** -> no mem_req; ls_done and ls_err at T1; ls_rdata=0.
- **Reset in WAIT:** assert rst_n=0 in WAIT, release, then pulse mem_rvalid -> all outputs are 0 immediately at assertion; no ls_done; the FSM stays in IDLE.
- **Back-to-back SW then LW:** -> the second mem_req rises exactly 2 cycles after the first ls_done. The core-visible stall pattern matches the latency rules above.
